laser_distance_avg: RTL and testbench

LASER_DISTANCE_AVG -- requirements
Module: laser_distance_avg

---
 rtl/laserdistance_pkg.sv | 17 +
 rtl/laser_avg_dp.sv | 72 +++++++
 rtl/laser_distance_avg.sv | 126 ++++++++++++
 tb/tb_laser_distance_avg.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laserdistance_pkg.sv
// Shared definitions for the laser distance averager: state encodings and
// controller constants, also imported by the testbench.
package laserdistance_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRE  = 3'd1,
        ST_GAP   = 3'd2,
        ST_COUNT = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } ld_state_e;

    // Laser pulse down-counter width; holds PULSE_CYCLES-1 for PULSE_CYCLES up to 15.
    localparam int PULSE_W = 4;

endpackage

// File: rtl/laser_avg_dp.sv
// Datapath for the distance averager: per-shot counter, accumulator, shot
// index and the held result D, all moved by strobes from the controller.
module laser_avg_dp #(
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_meas_i,
    input  logic             clr_cnt_i,
    input  logic             inc_i,
    input  logic             acc_i,
    input  logic             load_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_shot_o,
    output logic [WIDTH-1:0] d_o
);

    localparam int AW = WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0] LAST_IDX = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AVG_LOG2:0] idx_q, idx_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [AW-1:0]     acc_sum;

    // The final shot is accumulated and averaged on the same edge, so D
    // is taken from the sum including the current shot.
    assign acc_sum = acc_q + AW'(cnt_q);

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        idx_d = idx_q;
        d_d   = d_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        if (clr_meas_i) begin
            acc_d = '0;
            idx_d = '0;
        end else if (acc_i) begin
            acc_d = acc_sum;
            idx_d = idx_q + (AVG_LOG2 + 1)'(1);
        end
        if (load_i) begin
            d_d = WIDTH'(acc_sum >> AVG_LOG2);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            idx_q <= '0;
            d_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            d_q   <= d_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign last_shot_o = (idx_q == LAST_IDX);
    assign d_o         = d_q;

endmodule

// File: rtl/laser_distance_avg.sv
// Laser rangefinder controller: fires 2**AVG_LOG2 shots, times each
// reflection and reports the truncated average distance in clock cycles.
//
//   state | meaning
//   IDLE  | waiting for start button B
//   FIRE  | laser on for PULSE_CYCLES cycles
//   GAP   | one cycle, shot counter cleared
//   COUNT | counting cycles until sensor S reflects or timeout
//   DONE  | averaged result loaded into D, valid pulse
//   ERR   | shot timed out, valid+err pulse, D kept
module laser_distance_avg
    import laserdistance_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int AVG_LOG2     = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int TIMEOUT      = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             B,
    input  logic             S,
    output logic             L,
    output logic [WIDTH-1:0] D,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   TO_LAST    = WIDTH'(TIMEOUT - 1);

    ld_state_e          state_q;
    logic [PULSE_W-1:0] pulse_q;
    logic               valid_q;
    logic               err_q;

    logic             clr_meas, clr_cnt, inc, acc, load;
    logic [WIDTH-1:0] cnt;
    logic             last_shot;
    logic             timeout_hit;

    assign timeout_hit = (cnt == TO_LAST);

    always_comb begin
        clr_meas = (state_q == ST_IDLE) && B;
        clr_cnt  = (state_q == ST_GAP);
        inc      = (state_q == ST_COUNT) && !S;
        acc      = (state_q == ST_COUNT) && S;
        load     = acc && last_shot;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (B) begin
                        state_q <= ST_FIRE;
                        pulse_q <= PULSE_LAST;
                    end
                end
                ST_FIRE: begin
                    if (pulse_q == '0) begin
                        state_q <= ST_GAP;
                    end else begin
                        pulse_q <= pulse_q - PULSE_W'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (S) begin
                        if (last_shot) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_FIRE;
                            pulse_q <= PULSE_LAST;
                        end
                    end else if (timeout_hit) begin
                        state_q <= ST_ERR;
                        valid_q <= 1'b1;
                        err_q   <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    laser_avg_dp #(
        .WIDTH    (WIDTH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_dp (
        .clk         (clk),
        .reset       (reset),
        .clr_meas_i  (clr_meas),
        .clr_cnt_i   (clr_cnt),
        .inc_i       (inc),
        .acc_i       (acc),
        .load_i      (load),
        .cnt_o       (cnt),
        .last_shot_o (last_shot),
        .d_o         (D)
    );

    // Laser and busy come straight from state so they track it with no lag.
    assign L     = (state_q == ST_FIRE);
    assign busy  = (state_q != ST_IDLE);
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_laser_distance_avg.sv
// Self-checking bench for laser_distance_avg: expected results are queued as
// each measurement is launched and compared whenever valid pulses.
module tb_laser_distance_avg;
    import laserdistance_pkg::*;

    localparam int WIDTH        = 16;
    localparam int AVG_LOG2     = 2;
    localparam int PULSE_CYCLES = 2;
    localparam int TIMEOUT      = 1000;

    logic             clk;
    logic             reset;
    logic             B;
    logic             S;
    logic             L;
    logic [WIDTH-1:0] D;
    logic             valid;
    logic             err;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             e;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_cur;
    int   errors = 0;
    int   checks = 0;
    int   valid_seen = 0;
    bit   b_hold = 0;

    laser_distance_avg #(
        .WIDTH        (WIDTH),
        .AVG_LOG2     (AVG_LOG2),
        .PULSE_CYCLES (PULSE_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .B     (B),
        .S     (S),
        .L     (L),
        .D     (D),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: D=%0d err=%0b with nothing expected", D, err);
            end else begin
                exp_cur = exp_q.pop_front();
                if (D !== exp_cur.d || err !== exp_cur.e) begin
                    errors++;
                    $display("FAIL result: got D=%0d err=%0b, expected D=%0d err=%0b",
                             D, err, exp_cur.d, exp_cur.e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic start_meas();
        @(negedge clk);
        B = 1'b1;
    endtask

    // Waits for the laser pulse, checks its width, returns in the GAP cycle.
    task automatic wait_gap(input bit glitch, output int waited);
        int  lcount;
        bit  found;
        found  = 0;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            S = glitch;
            B = b_hold;
            waited++;
            if (L === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL shot_start: L never rose within 100 cycles");
        end
        lcount = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            S = glitch;
            if (L !== 1'b1) break;
            lcount++;
        end
        checks++;
        if (lcount != PULSE_CYCLES) begin
            errors++;
            $display("FAIL laser_width: L high %0d cycles, expected %0d", lcount, PULSE_CYCLES);
        end
    endtask

    // One shot: n COUNT cycles with S=0, then S=1 on the next COUNT cycle.
    task automatic do_shot(input int n, input bit glitch, output int waited);
        wait_gap(glitch, waited);
        repeat (n) begin
            @(negedge clk);
            S = 1'b0;
        end
        @(negedge clk);
        S = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int start;
        bit got;
        start = valid_seen;
        got   = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            S = 1'b0;
            #1;
            if (valid_seen != start) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_valid: no valid pulse within 200 cycles", name);
        end
    endtask

    task automatic run_meas(input int s0, input int s1, input int s2, input int s3,
                            input bit glitch, input string name);
        int w;
        start_meas();
        do_shot(s0, glitch, w);
        do_shot(s1, glitch, w);
        do_shot(s2, glitch, w);
        do_shot(s3, glitch, w);
        wait_valid(name);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        B = 1'b0;
        S = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (D !== '0)      begin errors++; $display("FAIL reset_D: got %0d, expected 0", D); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid); end
        if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b, expected 0", err); end
        if (L !== 1'b0)     begin errors++; $display("FAIL reset_L: got %b, expected 0", L); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_uniform();
        exp_q.push_back('{d: 16'd10, e: 1'b0});
        run_meas(10, 10, 10, 10, 1'b0, "uniform");
    endtask

    task automatic test_truncation();
        exp_q.push_back('{d: 16'd11, e: 1'b0});
        run_meas(10, 11, 12, 14, 1'b0, "truncation");
    endtask

    task automatic test_timeout();
        int w;
        int ncyc;
        exp_q.push_back('{d: 16'd11, e: 1'b1});
        start_meas();
        wait_gap(1'b0, w);
        S = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            #1;
            ncyc++;
            if (valid === 1'b1) break;
        end
        checks++;
        if (ncyc != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_latency: valid after %0d cycles past GAP, expected %0d",
                     ncyc, TIMEOUT + 1);
        end
        @(negedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b, expected 0", busy); end
        if (valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len: valid=%b, expected 0", valid); end
    endtask

    task automatic test_edge_values();
        exp_q.push_back('{d: 16'd0, e: 1'b0});
        run_meas(0, 0, 0, 0, 1'b0, "edge_zero");
        exp_q.push_back('{d: 16'd5, e: 1'b0});
        run_meas(5, 5, 5, 5, 1'b1, "edge_glitch");
    endtask

    task automatic test_abort();
        int w;
        int start;
        start_meas();
        do_shot(10, 1'b0, w);
        do_shot(10, 1'b0, w);
        wait_gap(1'b0, w);
        repeat (4) begin
            @(negedge clk);
            S = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks += 4;
        if (L !== 1'b0)     begin errors++; $display("FAIL abort_L: got %b, expected 0", L); end
        if (busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        if (D !== '0)       begin errors++; $display("FAIL abort_D: got %0d, expected 0", D); end
        if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b, expected 0", valid); end
        reset = 1'b1;
        start = valid_seen;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (valid_seen != start) begin
            errors++;
            $display("FAIL abort_no_valid: %0d valid pulses after abort, expected 0", valid_seen - start);
        end
        exp_q.push_back('{d: 16'd8, e: 1'b0});
        run_meas(7, 8, 9, 8, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        int w;
        b_hold = 1'b1;
        exp_q.push_back('{d: 16'd3, e: 1'b0});
        exp_q.push_back('{d: 16'd4, e: 1'b0});
        run_meas(3, 3, 3, 3, 1'b0, "b2b_first");
        do_shot(4, 1'b0, w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL b2b_restart: L rose %0d cycles after valid, expected 2", w);
        end
        b_hold = 1'b0;
        do_shot(4, 1'b0, w);
        do_shot(4, 1'b0, w);
        do_shot(4, 1'b0, w);
        wait_valid("b2b_second");
        B = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b after B released, expected 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_truncation();
        test_timeout();
        test_edge_values();
        test_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_results: %0d expected results never produced, expected 0",
                     exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
